joy_db15_tx: RTL and testbench
==============================

JOY_DB15_TX -- requirements
Module: joy_db15_tx

Interface
REQ-001 Parameter FRAME_BITS, default 24: bits shifted per frame, 12 per player.
REQ-002 Parameter TIMEOUT_CYC, default 1_000_000: clk cycles without a JOY_LOAD assertion before the link is declared lost.
REQ-003 clk  in  1  system clock, 40-50 MHz; all logic single-clock on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 joystick1  in  12  player-1 buttons, active-high, bit order LS FEDCBAUDLR.
REQ-006 joystick2  in  12  player-2 buttons, same format as joystick1.
REQ-007 JOY_LOAD  in  1  master parallel-load strobe, active-low, asynchronous to clk.
REQ-008 JOY_CLK  in  1  master shift clock, asynchronous to clk; shift on rising edge.
REQ-009 JOY_DATA  out  1  serial data to master, active-low per button, registered.
REQ-010 frame_done  out  1  one-clk pulse when the last bit of a frame has been shifted.
REQ-011 link_ok  out  1  high while load strobes arrive within TIMEOUT_CYC of each other.
REQ-012 bit_cnt  out  5  number of shift edges accepted since the last load, saturating at FRAME_BITS.

Function
REQ-013 JOY_LOAD and JOY_CLK shall each pass through a 2-flop synchronizer before any use.
REQ-014 A rising-edge detector on synchronized JOY_CLK shall produce a one-clk shift strobe.
REQ-015 While synchronized JOY_LOAD = 0, on every clk the shift register shall load {joystick2, joystick1}, with joystick1[0] at the output position; bit_cnt shall be 0.
REQ-016 On the clk where load is asserted, load shall win over a coincident shift strobe; the shift strobe shall be discarded.
REQ-017 When load = 1 and a shift strobe occurs with bit_cnt < FRAME_BITS, the register shall shift one position toward the output, fill with 0, and increment bit_cnt.
REQ-018 Shift strobes with bit_cnt = FRAME_BITS shall be ignored; the register and bit_cnt shall hold.
REQ-019 JOY_DATA shall be registered as the inverse of the output bit (pressed = 0, released = 1).
REQ-020 Once bit_cnt = FRAME_BITS, JOY_DATA shall be 1.
REQ-021 Bit order on the wire is P1 bits 0..11, then P2 bits 0..11.
REQ-022 Latency: JOY_DATA shall update exactly 4 clk edges after a JOY_CLK rising edge at the pin (2 sync, 1 edge detect, 1 output register).
REQ-023 Latency: JOY_DATA shall present joystick1[0] within 4 clk edges of JOY_LOAD falling at the pin.
REQ-024 frame_done shall pulse for exactly one clk on the clk where bit_cnt transitions from FRAME_BITS-1 to FRAME_BITS.
REQ-025 frame_done shall not pulse again until after a new load.
REQ-026 Watchdog: a counter shall clear on the falling edge of synchronized JOY_LOAD and otherwise increment, saturating at TIMEOUT_CYC.
REQ-027 link_ok shall be 1 while the watchdog counter < TIMEOUT_CYC, and 0 at saturation.
REQ-028 While link_ok = 0, JOY_DATA shall be forced to 1 regardless of register contents.
REQ-029 A load falling edge shall restore link_ok to 1 on the next clk.
REQ-030 A JOY_LOAD pulse shorter than 2 clk periods may be missed; no other behaviour is guaranteed for it.
REQ-031 A load held low indefinitely shall keep tracking the joystick inputs each clk.
REQ-032 A load asserted mid-frame shall abort the frame: reload the register and clear bit_cnt, with no frame_done pulse.

Reset
REQ-033 While reset is asserted: JOY_DATA = 1, frame_done = 0, link_ok = 0, bit_cnt = FRAME_BITS, shift register = 0, synchronizer flops = 1, watchdog = TIMEOUT_CYC.
REQ-034 After reset deasserts, no shift shall occur until a load has been seen; JOY_DATA shall stay 1.
REQ-035 A reset asserted mid-frame shall take effect asynchronously and discard the frame.

Verification
REQ-036 Basic frame: joystick1 = 12'h005, joystick2 = 12'h800, load pulse then 24 JOY_CLK edges (period >= 10 clk) -> JOY_DATA sequence 0,1,0, then 21×1 except bit 23 = 0; frame_done pulses once after edge 24.
REQ-037 Overrun: 30 JOY_CLK edges after a load -> edges 25-30 leave JOY_DATA = 1, bit_cnt = 24, no second frame_done.
REQ-038 Abort: load reasserted after edge 10 with new input 12'hFFF -> next edge sequence restarts at P1 bit 0 = 0; no frame_done for the aborted frame.
REQ-039 Collision: JOY_CLK rises on the same clk that synchronized load asserts -> bit_cnt = 0 and the first data bit is not skipped.
REQ-040 Timeout: TIMEOUT_CYC = 100, no load for 100 clk -> link_ok falls and JOY_DATA = 1; the next load restores link_ok one clk later.
REQ-041 Reset mid-frame at edge 7 -> all outputs take their reset values immediately; post-reset shift edges produce no change until a load.

Source files
------------

// File: rtl/joy_db15_tx.sv
// -----------------------------------------------------------------------------
// joy_db15_tx
// Serial joystick transmitter for a DB15 arcade link. The external master
// parallel-loads both players' buttons with JOY_LOAD (active-low) and then
// clocks them out one bit per rising JOY_CLK edge. Player 1 bit 0 goes out
// first and player 2 bit 11 goes out last. JOY_DATA is active-low: a pressed
// button is sent as 0. A watchdog declares the link lost when no load strobe
// arrives for TIMEOUT_CYC cycles. While the link is lost the line idles high.
//
// Ports
//   clk         system clock (40-50 MHz). Every register updates on its rising edge.
//   reset       asynchronous active-high reset
//   joystick1   player-1 buttons, active-high, bit order LS FEDCBAUDLR
//   joystick2   player-2 buttons, same format as joystick1
//   JOY_LOAD    master load strobe, active-low, asynchronous to clk
//   JOY_CLK     master shift clock, asynchronous to clk; shifts on its rising edge
//   JOY_DATA    registered serial data to the master, active-low per button
//   frame_done  one-cycle pulse when the last bit of a frame has been shifted
//   link_ok     high while load strobes keep arriving within TIMEOUT_CYC
//   bit_cnt     shift edges accepted since the last load, saturating at FRAME_BITS
// -----------------------------------------------------------------------------
module joy_db15_tx #(
    parameter int FRAME_BITS  = 24,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] joystick1,
    input  logic [11:0] joystick2,
    input  logic        JOY_LOAD,
    input  logic        JOY_CLK,
    output logic        JOY_DATA,
    output logic        frame_done,
    output logic        link_ok,
    output logic [4:0]  bit_cnt
);

    localparam int              WD_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_MAX   = WD_W'(TIMEOUT_CYC);
    localparam logic [4:0]      CNT_MAX  = 5'(FRAME_BITS);
    localparam logic [4:0]      CNT_LAST = 5'(FRAME_BITS - 1);

    // Synchronizers and edge-detect history. All of them reset high, so the
    // first clocks after reset cannot look like a load or a shift edge.
    logic [1:0]            load_sync_reg;
    logic [1:0]            clk_sync_reg;
    logic                  load_prev_reg;
    logic                  clk_prev_reg;

    logic [FRAME_BITS-1:0] shift_reg,      shift_next;
    logic [4:0]            bit_cnt_reg,    bit_cnt_next;
    logic                  frame_done_reg, frame_done_next;
    logic                  data_reg,       data_next;
    logic [WD_W-1:0]       wd_reg,         wd_next;

    logic load_active;
    logic load_fall;
    logic shift_strobe;
    logic cnt_full;
    logic link_ok_int;

    assign load_active  = ~load_sync_reg[1];
    assign load_fall    = load_prev_reg & ~load_sync_reg[1];
    assign shift_strobe = clk_sync_reg[1] & ~clk_prev_reg;
    assign cnt_full     = (bit_cnt_reg == CNT_MAX);
    assign link_ok_int  = (wd_reg != WD_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_sync_reg  <= 2'b11;
            clk_sync_reg   <= 2'b11;
            load_prev_reg  <= 1'b1;
            clk_prev_reg   <= 1'b1;
            shift_reg      <= '0;
            bit_cnt_reg    <= CNT_MAX;
            frame_done_reg <= 1'b0;
            data_reg       <= 1'b1;
            wd_reg         <= WD_MAX;
        end else begin
            load_sync_reg  <= {load_sync_reg[0], JOY_LOAD};
            clk_sync_reg   <= {clk_sync_reg[0], JOY_CLK};
            load_prev_reg  <= load_sync_reg[1];
            clk_prev_reg   <= clk_sync_reg[1];
            shift_reg      <= shift_next;
            bit_cnt_reg    <= bit_cnt_next;
            frame_done_reg <= frame_done_next;
            data_reg       <= data_next;
            wd_reg         <= wd_next;
        end
    end

    always_comb begin
        shift_next      = shift_reg;
        bit_cnt_next    = bit_cnt_reg;
        frame_done_next = 1'b0;

        if (load_active) begin
            // Load has priority. A shift edge that arrives on the same cycle is
            // consumed here and dropped, so bit 0 is never skipped.
            shift_next   = FRAME_BITS'({joystick2, joystick1});
            bit_cnt_next = '0;
        end else if (shift_strobe && !cnt_full) begin
            shift_next      = {1'b0, shift_reg[FRAME_BITS-1:1]};
            bit_cnt_next    = bit_cnt_reg + 5'd1;
            frame_done_next = (bit_cnt_reg == CNT_LAST);
        end

        // The counter clears only on a load falling edge. A load held low
        // still lets the counter advance.
        if (load_fall)
            wd_next = '0;
        else if (link_ok_int)
            wd_next = wd_reg + WD_W'(1);
        else
            wd_next = wd_reg;

        // Drive the line high (idle) when the link is lost or the frame has
        // been fully sent.
        data_next = (link_ok_int && !cnt_full) ? ~shift_reg[0] : 1'b1;
    end

    assign JOY_DATA   = data_reg;
    assign frame_done = frame_done_reg;
    assign link_ok    = link_ok_int;
    assign bit_cnt    = bit_cnt_reg;

endmodule

// File: tb/tb_joy_db15_tx.sv
module tb_joy_db15_tx;

    localparam int FB = 24;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] joystick1 = '0;
    logic [11:0] joystick2 = '0;
    logic        JOY_LOAD = 1'b1;
    logic        JOY_CLK = 1'b0;

    logic        JOY_DATA, frame_done, link_ok;
    logic [4:0]  bit_cnt;
    logic        wd_data, wd_frame_done, wd_link_ok;
    logic [4:0]  wd_bit_cnt;

    int n_cmp = 0;
    int n_mis = 0;
    int fd_count = 0;
    int fd0;

    always #5 clk = ~clk;

    joy_db15_tx #(.FRAME_BITS(24), .TIMEOUT_CYC(5000)) dut (
        .clk(clk), .reset(reset), .joystick1(joystick1), .joystick2(joystick2),
        .JOY_LOAD(JOY_LOAD), .JOY_CLK(JOY_CLK), .JOY_DATA(JOY_DATA),
        .frame_done(frame_done), .link_ok(link_ok), .bit_cnt(bit_cnt)
    );

    joy_db15_tx #(.FRAME_BITS(24), .TIMEOUT_CYC(100)) dut_wd (
        .clk(clk), .reset(reset), .joystick1(joystick1), .joystick2(joystick2),
        .JOY_LOAD(JOY_LOAD), .JOY_CLK(JOY_CLK), .JOY_DATA(wd_data),
        .frame_done(wd_frame_done), .link_ok(wd_link_ok), .bit_cnt(wd_bit_cnt)
    );

    // Count cycles where frame_done is high. A pulse wider than one cycle is
    // counted more than once.
    always @(negedge clk) if (frame_done === 1'b1) fd_count++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected line level after k accepted shift edges: bit k of the 24-bit
    // word p2*4096 + p1, inverted. The line is high once the frame is exhausted.
    function automatic logic exp_data(input logic [11:0] p1, input logic [11:0] p2, input int k);
        int word;
        if (k >= FB) return 1'b1;
        word = int'(p2) * 4096 + int'(p1);
        return ((word >> k) % 2) == 0;
    endfunction

    task automatic do_load();
        JOY_LOAD = 1'b0;
        cyc(4);
        JOY_LOAD = 1'b1;
        cyc(4);
    endtask

    task automatic edge_clk();
        int half;
        half = 5 + $urandom_range(0, 2);
        JOY_CLK = 1'b1;
        cyc(half);
        JOY_CLK = 1'b0;
        cyc(half);
    endtask

    task automatic run_edges(input string tag, input int from, input int to);
        for (int k = from; k <= to; k++) begin
            edge_clk();
            check($sformatf("%s data k=%0d", tag, k), 32'(JOY_DATA),
                  32'(exp_data(joystick1, joystick2, k)));
            check($sformatf("%s cnt k=%0d", tag, k), 32'(bit_cnt),
                  32'((k > FB) ? FB : k));
        end
    endtask

    initial begin
        // Reset state
        cyc(3);
        check("rst data", 32'(JOY_DATA), 32'(1));
        check("rst frame_done", 32'(frame_done), 32'(0));
        check("rst link_ok", 32'(link_ok), 32'(0));
        check("rst bit_cnt", 32'(bit_cnt), 32'(FB));
        check("rst wd link_ok", 32'(wd_link_ok), 32'(0));

        // Before any load, shift edges do nothing
        reset = 1'b0;
        cyc(2);
        for (int i = 0; i < 3; i++) begin
            edge_clk();
            check("noload data", 32'(JOY_DATA), 32'(1));
            check("noload cnt", 32'(bit_cnt), 32'(FB));
        end

        // Basic frame with load and shift latency checks
        joystick1 = 12'h005;
        joystick2 = 12'h800;
        fd0 = fd_count;
        JOY_LOAD = 1'b0;
        cyc(4);
        check("load latency data", 32'(JOY_DATA), 32'(0));
        cyc(1);
        JOY_LOAD = 1'b1;
        cyc(4);
        check("load link_ok", 32'(link_ok), 32'(1));
        check("load cnt", 32'(bit_cnt), 32'(0));
        JOY_CLK = 1'b1;
        cyc(3);
        check("edge latency 3", 32'(JOY_DATA), 32'(0));
        cyc(1);
        check("edge latency 4", 32'(JOY_DATA), 32'(1));
        cyc(2);
        JOY_CLK = 1'b0;
        cyc(5);
        check("basic cnt k=1", 32'(bit_cnt), 32'(1));
        run_edges("basic", 2, 24);
        check("basic frame_done", 32'(fd_count), 32'(fd0 + 1));
        run_edges("overrun", 25, 30);
        check("overrun frame_done", 32'(fd_count), 32'(fd0 + 1));

        // Random frames
        for (int r = 0; r < 4; r++) begin
            joystick1 = 12'($urandom);
            joystick2 = 12'($urandom);
            fd0 = fd_count;
            do_load();
            check("rand data k=0", 32'(JOY_DATA), 32'(exp_data(joystick1, joystick2, 0)));
            run_edges("rand", 1, 25);
            check("rand frame_done", 32'(fd_count), 32'(fd0 + 1));
        end

        // Abort mid-frame
        joystick1 = 12'($urandom);
        joystick2 = 12'($urandom);
        fd0 = fd_count;
        do_load();
        run_edges("pre-abort", 1, 10);
        joystick1 = 12'hFFF;
        joystick2 = 12'($urandom);
        do_load();
        check("abort data", 32'(JOY_DATA), 32'(0));
        check("abort cnt", 32'(bit_cnt), 32'(0));
        check("abort no frame_done", 32'(fd_count), 32'(fd0));
        run_edges("abort", 1, 24);
        check("abort frame_done", 32'(fd_count), 32'(fd0 + 1));

        // Collision: shift edge and load reach the synchronizers together
        joystick1 = 12'($urandom) | 12'h001;
        joystick2 = 12'($urandom);
        JOY_LOAD = 1'b0;
        JOY_CLK  = 1'b1;
        cyc(4);
        check("collide cnt", 32'(bit_cnt), 32'(0));
        check("collide data", 32'(JOY_DATA), 32'(0));
        cyc(2);
        JOY_LOAD = 1'b1;
        cyc(4);
        JOY_CLK = 1'b0;
        cyc(5);
        check("collide cnt hold", 32'(bit_cnt), 32'(0));
        run_edges("collide", 1, 24);

        // Watchdog timeout on the TIMEOUT_CYC=100 instance
        joystick1 = 12'($urandom) | 12'h001;
        JOY_LOAD = 1'b0;
        cyc(3);
        check("wd link after fall", 32'(wd_link_ok), 32'(1));
        cyc(1);
        JOY_LOAD = 1'b1;
        check("wd data live", 32'(wd_data), 32'(0));
        cyc(98);
        check("wd link at 99", 32'(wd_link_ok), 32'(1));
        cyc(1);
        check("wd link at 100", 32'(wd_link_ok), 32'(0));
        cyc(2);
        check("wd data forced", 32'(wd_data), 32'(1));
        JOY_LOAD = 1'b0;
        cyc(2);
        check("wd link before sync", 32'(wd_link_ok), 32'(0));
        cyc(1);
        check("wd link restored", 32'(wd_link_ok), 32'(1));
        cyc(1);
        check("wd data restored", 32'(wd_data), 32'(0));
        JOY_LOAD = 1'b1;
        cyc(4);

        // Reset mid-frame
        joystick1 = 12'($urandom);
        joystick2 = 12'($urandom);
        fd0 = fd_count;
        do_load();
        run_edges("pre-reset", 1, 7);
        #2;
        reset = 1'b1;
        #1;
        check("midrst data", 32'(JOY_DATA), 32'(1));
        check("midrst frame_done", 32'(frame_done), 32'(0));
        check("midrst link_ok", 32'(link_ok), 32'(0));
        check("midrst cnt", 32'(bit_cnt), 32'(FB));
        cyc(2);
        reset = 1'b0;
        cyc(2);
        for (int i = 0; i < 3; i++) begin
            edge_clk();
            check("postrst data", 32'(JOY_DATA), 32'(1));
            check("postrst cnt", 32'(bit_cnt), 32'(FB));
        end
        check("postrst no frame_done", 32'(fd_count), 32'(fd0));
        do_load();
        run_edges("postrst", 1, 24);
        check("postrst frame_done", 32'(fd_count), 32'(fd0 + 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
